// File: rtl/qos_wrr_scheduler_if.sv
// FIFO-side signal bundle of qos_wrr_scheduler: input VC FIFO heads/empties and output VC FIFO strobes.
interface qos_wrr_scheduler_if #(
  parameter int DATA_W = 12
) ();
  logic [3:0]        empty;
  logic [DATA_W-1:0] head0;
  logic [DATA_W-1:0] head1;
  logic [DATA_W-1:0] head2;
  logic [DATA_W-1:0] head3;
  logic [3:0]        almost_full;
  logic [3:0]        pop;
  logic [3:0]        push;
  logic [DATA_W-1:0] data_out;

  modport master (
    input  empty, head0, head1, head2, head3, almost_full,
    output pop, push, data_out
  );

  modport slave (
    output empty, head0, head1, head2, head3, almost_full,
    input  pop, push, data_out
  );
endinterface

// File: rtl/qos_wrr_scheduler.sv
// Weighted round-robin scheduler from four input VC FIFOs to four output VC FIFOs.
// Optional macro QOS_STRICT_PRIO0_EN: queue 0 pre-empts WRR whenever it is eligible.
module qos_wrr_scheduler #(
  parameter int DATA_W   = 12,
  parameter int DEST_LSB = 8,
  parameter int WEIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  active,
  input  logic                  cfg_load,
  input  logic [4*WEIGHT_W-1:0] weight_in,
  qos_wrr_scheduler_if.master   bus,
  output logic [1:0]            cur_q,
  output logic                  busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SERVE = 2'd2;

  logic [1:0]          state;
  logic [1:0]          ptr;
  logic [WEIGHT_W-1:0] credit;
  logic [WEIGHT_W-1:0] weight [4];
  logic [DATA_W-1:0]   heads  [4];
  logic [3:0]          eligible;
  logic                wrrPop;
  logic                strictHit;
  logic [1:0]          popIdx;
  logic [DATA_W-1:0]   selHead;
  logic [1:0]          selDest;

  assign heads[0] = bus.head0;
  assign heads[1] = bus.head1;
  assign heads[2] = bus.head2;
  assign heads[3] = bus.head3;

  // Destination almost_full is checked against the head word's own class bits.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      eligible[i] = !bus.empty[i] && (weight[i] != '0) &&
                    !bus.almost_full[heads[i][DEST_LSB +: 2]];
    end
  end

  always_comb begin
    strictHit = 1'b0;
    wrrPop    = 1'b0;
    if (reset && active && (state == SERVE)) begin
`ifdef QOS_STRICT_PRIO0_EN
      strictHit = eligible[0];
`endif
      wrrPop = !strictHit && eligible[ptr] && (credit != '0);
    end
  end

  assign popIdx  = strictHit ? 2'd0 : ptr;
  assign bus.pop = (strictHit || wrrPop) ? (4'b0001 << popIdx) : 4'b0000;
  assign selHead = heads[popIdx];
  assign selDest = selHead[DEST_LSB +: 2];

  assign cur_q = ptr;
  assign busy  = (state == SERVE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      ptr    <= '0;
      credit <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        weight[i] <= WEIGHT_W'(1);
      end
    end else begin
      case (state)
        IDLE: begin
          if (cfg_load) begin
            for (int unsigned i = 0; i < 4; i++) begin
              weight[i] <= weight_in[i*WEIGHT_W +: WEIGHT_W];
            end
          end
          if (active) state <= LOAD;
        end
        LOAD: begin
          credit <= weight[ptr];
          state  <= SERVE;
        end
        SERVE: begin
          if (!active) begin
            state <= IDLE;
          end else if (!strictHit) begin
            // Last credit spent or queue not servable: hand the pointer on.
            if (wrrPop) credit <= credit - WEIGHT_W'(1);
            if (!wrrPop || (credit == WEIGHT_W'(1))) begin
              ptr   <= ptr + 2'd1;
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.push     <= '0;
      bus.data_out <= '0;
    end else if (strictHit || wrrPop) begin
      bus.push     <= 4'b0001 << selDest;
      bus.data_out <= selHead;
    end else begin
      bus.push <= '0;
    end
  end

endmodule

// File: tb/tb_qos_wrr_scheduler.sv
// Directed-vector bench for qos_wrr_scheduler (default build, strict priority disabled).
module tb_qos_wrr_scheduler;

  localparam logic [11:0] H0  = 12'h0A0;
  localparam logic [11:0] H1  = 12'h1B1;
  localparam logic [11:0] H1A = 12'h2B1;
  localparam logic [11:0] H2  = 12'h2C2;
  localparam logic [11:0] H3  = 12'h3D3;

  logic        clk = 1'b0;
  logic        reset;
  logic        active;
  logic        cfgLoad;
  logic [15:0] weightIn;
  logic [1:0]  curQ;
  logic        busy;
  int          checks   = 0;
  int          failures = 0;

  qos_wrr_scheduler_if #(.DATA_W(12)) bus ();

  qos_wrr_scheduler #(
    .DATA_W  (12),
    .DEST_LSB(8),
    .WEIGHT_W(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .active   (active),
    .cfg_load (cfgLoad),
    .weight_in(weightIn),
    .bus      (bus.master),
    .cur_q    (curQ),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are set just after a rising edge; outputs of that cycle are checked on the falling edge.
  task automatic cyc(input string tag, input logic [3:0] ePop, input logic [3:0] ePush,
                     input logic [11:0] eData, input logic [1:0] eQ, input logic eBusy);
    @(negedge clk);
    checkEq({tag, ".pop"},  32'(bus.pop),      32'(ePop));
    checkEq({tag, ".push"}, 32'(bus.push),     32'(ePush));
    checkEq({tag, ".data"}, 32'(bus.data_out), 32'(eData));
    checkEq({tag, ".q"},    32'(curQ),         32'(eQ));
    checkEq({tag, ".busy"}, 32'(busy),         32'(eBusy));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset           = 1'b0;
    active          = 1'b0;
    cfgLoad         = 1'b0;
    weightIn        = '0;
    bus.empty       = 4'hF;
    bus.almost_full = 4'h0;
    bus.head0       = H0;
    bus.head1       = H1;
    bus.head2       = H2;
    bus.head3       = H3;

    cyc("rst", 4'h0, 4'h0, 12'h000, 2'd0, 1'b0);

    // Equal weights: one pop per queue, LOAD gap between pops, push one cycle later.
    reset = 1'b1; cfgLoad = 1'b1; weightIn = 16'h1111; bus.empty = 4'h0;
    cyc("t1a", 4'h0, 4'h0, 12'h000, 2'd0, 1'b0);
    cfgLoad = 1'b0; active = 1'b1;
    cyc("t1b", 4'h0, 4'h0, 12'h000, 2'd0, 1'b0);
    cyc("t1c", 4'h0, 4'h0, 12'h000, 2'd0, 1'b0);
    cyc("t1d", 4'h1, 4'h0, 12'h000, 2'd0, 1'b1);
    cyc("t1e", 4'h0, 4'h1, H0,      2'd1, 1'b0);
    cyc("t1f", 4'h2, 4'h0, H0,      2'd1, 1'b1);
    cyc("t1g", 4'h0, 4'h2, H1,      2'd2, 1'b0);
    cyc("t1h", 4'h4, 4'h0, H1,      2'd2, 1'b1);
    cyc("t1i", 4'h0, 4'h4, H2,      2'd3, 1'b0);
    cyc("t1j", 4'h8, 4'h0, H2,      2'd3, 1'b1);
    cyc("t1k", 4'h0, 4'h8, H3,      2'd0, 1'b0);
    cyc("t1l", 4'h1, 4'h0, H3,      2'd0, 1'b1);

    // Drop to IDLE, then cfg_load together with active: weights {3,1,0,2}.
    active = 1'b0;
    cyc("t2a", 4'h0, 4'h1, H0, 2'd1, 1'b0);
    cyc("t2b", 4'h0, 4'h0, H0, 2'd1, 1'b1);
    cfgLoad = 1'b1; weightIn = 16'h2013; active = 1'b1;
    cyc("t2c", 4'h0, 4'h0, H0, 2'd1, 1'b0);
    cfgLoad = 1'b0;
    cyc("t2d", 4'h0, 4'h0, H0, 2'd1, 1'b0);
    cyc("t2e", 4'h2, 4'h0, H0, 2'd1, 1'b1);
    cyc("t2f", 4'h0, 4'h2, H1, 2'd2, 1'b0);
    cyc("t2g", 4'h0, 4'h0, H1, 2'd2, 1'b1);
    cyc("t2h", 4'h0, 4'h0, H1, 2'd3, 1'b0);
    cyc("t2i", 4'h8, 4'h0, H1, 2'd3, 1'b1);
    cyc("t2j", 4'h8, 4'h8, H3, 2'd3, 1'b1);
    cyc("t2k", 4'h0, 4'h8, H3, 2'd0, 1'b0);
    cyc("t2l", 4'h1, 4'h0, H3, 2'd0, 1'b1);
    cyc("t2m", 4'h1, 4'h1, H0, 2'd0, 1'b1);
    cyc("t2n", 4'h1, 4'h1, H0, 2'd0, 1'b1);

    // Q1 head targets output 2, which is almost full.
    bus.head1 = H1A; bus.almost_full = 4'b0100;
    cyc("t3a", 4'h0, 4'h1, H0, 2'd1, 1'b0);
    cyc("t3b", 4'h0, 4'h0, H0, 2'd1, 1'b1);
    cyc("t3c", 4'h0, 4'h0, H0, 2'd2, 1'b0);
    cyc("t3d", 4'h0, 4'h0, H0, 2'd2, 1'b1);
    cyc("t3e", 4'h0, 4'h0, H0, 2'd3, 1'b0);
    cyc("t3f", 4'h8, 4'h0, H0, 2'd3, 1'b1);
    cyc("t3g", 4'h8, 4'h8, H3, 2'd3, 1'b1);
    cyc("t3h", 4'h0, 4'h8, H3, 2'd0, 1'b0);
    cyc("t3i", 4'h1, 4'h0, H3, 2'd0, 1'b1);
    cyc("t3j", 4'h1, 4'h1, H0, 2'd0, 1'b1);
    cyc("t3k", 4'h1, 4'h1, H0, 2'd0, 1'b1);
    bus.almost_full = 4'h0;
    cyc("t3l", 4'h0, 4'h1, H0, 2'd1, 1'b0);
    cyc("t3m", 4'h2, 4'h0, H0, 2'd1, 1'b1);

    // All queues empty for 20 cycles, then only Q3 has data.
    bus.empty = 4'hF;
    cyc("t4a", 4'h0, 4'h4, H1A, 2'd2, 1'b0);
    for (int k = 0; k < 26; k++) begin
      if (k == 20) bus.empty = 4'b0111;
      cyc("t4idle", 4'h0, 4'h0, H1A, 2'((2 + (k + 1) / 2) % 4), (k % 2) == 0);
    end
    cyc("t4p",  4'h8, 4'h0, H1A, 2'd3, 1'b1);
    cyc("t4q",  4'h8, 4'h8, H3,  2'd3, 1'b1);

    // Active drops after first pop of a weight-3 burst; cfg_load while active is ignored.
    bus.empty = 4'h0;
    cyc("t5a", 4'h0, 4'h8, H3, 2'd0, 1'b0);
    cyc("t5b", 4'h1, 4'h0, H3, 2'd0, 1'b1);
    active = 1'b0;
    cyc("t5c", 4'h0, 4'h1, H0, 2'd0, 1'b1);
    active = 1'b1;
    cyc("t5d", 4'h0, 4'h0, H0, 2'd0, 1'b0);
    cfgLoad = 1'b1; weightIn = 16'h1111;
    cyc("t5e", 4'h0, 4'h0, H0, 2'd0, 1'b0);
    cyc("t5f", 4'h1, 4'h0, H0, 2'd0, 1'b1);
    cfgLoad = 1'b0;
    cyc("t5g", 4'h1, 4'h1, H0, 2'd0, 1'b1);
    cyc("t5h", 4'h1, 4'h1, H0, 2'd0, 1'b1);
    cyc("t5i", 4'h0, 4'h1, H0, 2'd1, 1'b0);

    // Reset asserted mid-SERVE: no pop that cycle, reset values after, weights back to 1.
    reset = 1'b0;
    cyc("t6a", 4'h0, 4'h0, H0,      2'd1, 1'b1);
    cyc("t6b", 4'h0, 4'h0, 12'h000, 2'd0, 1'b0);
    reset = 1'b1;
    cyc("t6c", 4'h0, 4'h0, 12'h000, 2'd0, 1'b0);
    cyc("t6d", 4'h0, 4'h0, 12'h000, 2'd0, 1'b0);
    cyc("t6e", 4'h1, 4'h0, 12'h000, 2'd0, 1'b1);
    cyc("t6f", 4'h0, 4'h1, H0,      2'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
